// File: rtl/uart_byte_tx_pkg.sv
// Shared UART definitions: parity codes, transmitter FSM states, baud divisor rounding.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_byte_tx_pkg;

  localparam int UART_PAR_NONE = 0;
  localparam int UART_PAR_ODD  = 1;
  localparam int UART_PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Clocks per bit, rounded to nearest so the baud error stays within half a clock.
  function automatic int uart_baud_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_byte_tx_baud_gen.sv
// Bit-period counter: counts 0..DIV-1 while enabled and flags the wrap clock.
// Latency: tick is combinational from the registered count (asserted on the count's last clock).
// Backpressure: none; clr has priority over en.
module uart_byte_tx_baud_gen #(
  parameter int DIV = 10,
  parameter int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tick
);

  assign tick = en && (int'(cnt) == DIV - 1);

  // Count one bit period; restart from zero on clear or on wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_byte_tx.sv
// UART transmitter: one word per valid/ready handshake, framed start/data/[parity]/stop, LSB first.
// Latency: line falls on the clock after the accepting edge; o_done on the last clock of the frame.
// Backpressure: o_ready low for the whole frame; i_valid while busy is ignored (no buffering).
module uart_byte_tx
  import uart_byte_tx_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       i_sysclk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_uart_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int         BAUD_DIV   = uart_baud_div(CLK_FREQ, BAUD);
  localparam int         CW         = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [7:0] DATA_MASK  = 8'((1 << DATA_BITS) - 1);
  localparam bit         HAS_PARITY = (PARITY != UART_PAR_NONE);

  // Refuse to elaborate an unsupported frame format or a divisor too small to time a bit.
  if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || BAUD_DIV < 2) begin : g_bad_params
    $error("uart_byte_tx: illegal DATA_BITS/PARITY/STOP_BITS or BAUD_DIV < 2");
  end

  uart_state_t   state;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic          stop_idx;
  logic          par_bit;
  logic [CW-1:0] baud_cnt;
  logic          baud_tick;
  logic          baud_en;
  logic          accept;
  logic          last_data;
  logic          last_stop;
  logic          pre_wrap;

  assign accept    = i_valid && o_ready;
  assign baud_en   = (state != ST_IDLE);
  assign last_data = (int'(bit_idx) == DATA_BITS - 1);
  assign last_stop = (int'(stop_idx) == STOP_BITS - 1);
  // One clock before wrap, so the registered o_done lands on the final clock of the frame.
  assign pre_wrap  = (int'(baud_cnt) == BAUD_DIV - 2);

  uart_byte_tx_baud_gen #(
    .DIV (BAUD_DIV),
    .CW  (CW)
  ) u_baud (
    .clk  (i_sysclk),
    .rst  (i_rst),
    .clr  (accept),
    .en   (baud_en),
    .cnt  (baud_cnt),
    .tick (baud_tick)
  );

  // Frame sequencer: latches the word on acceptance and drives every output from registers.
  always_ff @(posedge i_sysclk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      o_uart_tx <= 1'b1;
      o_ready   <= 1'b1;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      shreg     <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      par_bit   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          o_uart_tx <= 1'b1;
          if (accept) begin
            shreg     <= i_data & DATA_MASK;
            par_bit   <= (^(i_data & DATA_MASK)) ^ (PARITY == UART_PAR_ODD);
            o_uart_tx <= 1'b0;
            o_ready   <= 1'b0;
            o_busy    <= 1'b1;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            o_uart_tx <= shreg[0];
            shreg     <= {1'b0, shreg[7:1]};
            bit_idx   <= '0;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            if (last_data) begin
              if (HAS_PARITY) begin
                o_uart_tx <= par_bit;
                state     <= ST_PARITY;
              end else begin
                o_uart_tx <= 1'b1;
                stop_idx  <= 1'b0;
                state     <= ST_STOP;
              end
            end else begin
              o_uart_tx <= shreg[0];
              shreg     <= {1'b0, shreg[7:1]};
              bit_idx   <= bit_idx + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (baud_tick) begin
            o_uart_tx <= 1'b1;
            stop_idx  <= 1'b0;
            state     <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (last_stop && pre_wrap) begin
            o_done <= 1'b1;
          end
          if (baud_tick) begin
            if (last_stop) begin
              o_ready <= 1'b1;
              o_busy  <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          o_uart_tx <= 1'b1;
          o_ready   <= 1'b1;
          o_busy    <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx: four frame formats at BAUD_DIV=10 sharing one clock and reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_byte_tx;

  logic       clk;
  logic       rst;
  logic [7:0] data [4];
  logic [3:0] valid;
  logic [3:0] ready;
  logic [3:0] tx;
  logic [3:0] busy;
  logic [3:0] done;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt [4] = '{0, 0, 0, 0};
  logic samp [400];

  // Instance 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2
  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_byte_tx #(
      .CLK_FREQ  (1_000_000),
      .BAUD      (100_000),
      .DATA_BITS (g == 3 ? 7 : 8),
      .PARITY    (g == 1 ? 2 : (g == 2 ? 1 : 0)),
      .STOP_BITS (g == 3 ? 2 : 1)
    ) u_dut (
      .i_sysclk  (clk),
      .i_rst     (rst),
      .i_data    (data[g]),
      .i_valid   (valid[g]),
      .o_ready   (ready[g]),
      .o_uart_tx (tx[g]),
      .o_busy    (busy[g]),
      .o_done    (done[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tally o_done pulses per instance.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (done[k] === 1'b1) done_cnt[k]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present a word and wait (bounded) for the accepting edge; optionally keep valid high.
  task automatic send(input int k, input logic [7:0] d, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    data[k]  = d;
    valid[k] = 1'b1;
    while (ready[k] !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", (n < 500), 1);
    @(posedge clk);
    #1;
    if (!hold) valid[k] = 1'b0;
    chk("latency", tx[k], 1'b0);
  endtask

  // Sample the line at each falling edge from the start bit until o_done.
  // gap = high samples seen before the start bit, len = samples from start fall to o_done inclusive.
  task automatic capture(input int k, input int nbits, output logic [15:0] vec,
                         output int len, output int gap, output logic stable);
    gap = 0;
    @(negedge clk);
    while (tx[k] !== 1'b0 && gap < 300) begin
      @(negedge clk);
      gap++;
    end
    len = 0;
    while (len < 400) begin
      samp[len] = tx[k];
      len++;
      if (done[k] === 1'b1) break;
      @(negedge clk);
    end
    vec    = '0;
    stable = 1'b1;
    for (int b = 0; b < nbits; b++) begin
      vec[b] = samp[b * 10 + 5];
      for (int j = 0; j < 10; j++) begin
        if (samp[b * 10 + j] !== samp[b * 10]) stable = 1'b0;
      end
    end
  endtask

  // Line must stay high and no o_done may appear for a while.
  task automatic idle_check(input int k, input string tag);
    int lows;
    int base;
    lows = 0;
    @(negedge clk);
    base = done_cnt[k];
    repeat (150) begin
      @(negedge clk);
      if (tx[k] !== 1'b1) lows++;
    end
    chk({tag, "_line_low"}, lows, 0);
    chk({tag, "_done"}, done_cnt[k] - base, 0);
  endtask

  logic [15:0] vec;
  int          len;
  int          gap;
  logic        st;
  int          base;

  initial begin
    rst   = 1'b1;
    valid = '0;
    for (int k = 0; k < 4; k++) data[k] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 4'hF);
    chk("rst_ready", ready, 4'hF);
    chk("rst_busy", busy, 4'h0);
    chk("rst_done", done, 4'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
    send(0, 8'hA5, 1'b0);
    capture(0, 10, vec, len, gap, st);
    chk("t1_bits", vec, 16'h034A);
    chk("t1_len", len, 100);
    chk("t1_gap", gap, 0);
    chk("t1_stable", st, 1'b1);
    chk("t1_busy_at_done", busy[0], 1'b1);
    @(negedge clk);
    chk("t1_done_width", done[0], 1'b0);
    chk("t1_ready_after", ready[0], 1'b1);
    chk("t1_done_cnt", done_cnt[0], 1);

    // 8E1 / 8O1 0x07: parity 1 / 0
    send(1, 8'h07, 1'b0);
    capture(1, 11, vec, len, gap, st);
    chk("t2e_bits", vec, 16'h060E);
    chk("t2e_len", len, 110);
    chk("t2e_stable", st, 1'b1);
    send(2, 8'h07, 1'b0);
    capture(2, 11, vec, len, gap, st);
    chk("t2o_bits", vec, 16'h040E);
    chk("t2o_len", len, 110);
    chk("t2o_stable", st, 1'b1);

    // 7N2 0xFF: bit 7 dropped, two stop bits
    send(3, 8'hFF, 1'b0);
    capture(3, 10, vec, len, gap, st);
    chk("t3_bits", vec, 16'h03FE);
    chk("t3_len", len, 100);
    chk("t3_stable", st, 1'b1);

    // Back-to-back with valid held: 0x55 then 0xAA, one idle clock between frames
    send(0, 8'h55, 1'b1);
    data[0] = 8'hAA;
    capture(0, 10, vec, len, gap, st);
    chk("t4a_bits", vec, 16'h02AA);
    chk("t4a_len", len, 100);
    capture(0, 10, vec, len, gap, st);
    valid[0] = 1'b0;
    chk("t4b_gap", gap, 1);
    chk("t4b_bits", vec, 16'h0354);
    chk("t4b_len", len, 100);
    chk("t4b_stable", st, 1'b1);
    idle_check(0, "t4_after");

    // Valid pulse with new data mid-frame is ignored
    send(0, 8'h3C, 1'b0);
    fork
      capture(0, 10, vec, len, gap, st);
      begin
        repeat (35) @(negedge clk);
        data[0]  = 8'h00;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
      end
    join
    chk("t5_bits", vec, 16'h0278);
    chk("t5_len", len, 100);
    idle_check(0, "t5_after");

    // Reset during data bit 3 (0xF0 -> bit 3 is low)
    send(0, 8'hF0, 1'b0);
    repeat (44) @(negedge clk);
    chk("t6_in_bit3", tx[0], 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_rst_tx", tx[0], 1'b1);
    chk("t6_rst_ready", ready[0], 1'b1);
    chk("t6_rst_busy", busy[0], 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_check(0, "t6_abort");
    send(0, 8'h5A, 1'b0);
    capture(0, 10, vec, len, gap, st);
    chk("t6_bits", vec, 16'h02B4);
    chk("t6_len", len, 100);
    chk("t6_stable", st, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
